// File: rtl/freq_meter_mc_if.sv
// rtl/freq_meter_mc_if.sv - control and result signals of the multi-channel frequency meter
// Ports (signals):
//   en        run enable (master -> meter)
//   gate_sel  window length select: 0=full, 1=/10, 2=/100, 3=/1000 (master -> meter)
//   sig_in    asynchronous signals to measure (master -> meter)
//   freq      published counts, channel k at [k*CNT_W +: CNT_W] (meter -> master)
//   ovf       per-channel overflow of the last published window (meter -> master)
//   valid     one-cycle strobe: freq/ovf updated (meter -> master)
//   busy      a gate window is open (meter -> master)
interface freq_meter_mc_if #(
    parameter int NCH   = 4,
    parameter int CNT_W = 20
);
    logic                   en;
    logic [1:0]             gate_sel;
    logic [NCH-1:0]         sig_in;
    logic [NCH*CNT_W-1:0]   freq;
    logic [NCH-1:0]         ovf;
    logic                   valid;
    logic                   busy;

    modport master (
        output en, gate_sel, sig_in,
        input  freq, ovf, valid, busy
    );

    modport slave (
        input  en, gate_sel, sig_in,
        output freq, ovf, valid, busy
    );
endinterface

// File: rtl/freq_meter_mc.sv
// rtl/freq_meter_mc.sv - multi-channel gated rising-edge frequency meter
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   mtr    freq_meter_mc_if.slave: en, gate_sel, sig_in in; freq, ovf, valid, busy out
module freq_meter_mc #(
    parameter int NCH         = 4,
    parameter int CNT_W       = 20,
    parameter int GATE_CYCLES = 125000000,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    freq_meter_mc_if.slave    mtr
);
    localparam int GW = $clog2(GATE_CYCLES + 1);
    localparam logic [GW-1:0]    GL0     = GW'(GATE_CYCLES);
    localparam logic [GW-1:0]    GL1     = GW'(GATE_CYCLES / 10);
    localparam logic [GW-1:0]    GL2     = GW'(GATE_CYCLES / 100);
    localparam logic [GW-1:0]    GL3     = GW'(GATE_CYCLES / 1000);
    localparam logic [GW-1:0]    G_ONE   = GW'(1);
    localparam logic [CNT_W-1:0] C_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] C_MAX   = '1;

    typedef enum logic [1:0] {IDLE, GATE, LATCH} state_t;

    state_t                                 state_q, state_d;
    logic [SYNC_STAGES-1:0][NCH-1:0]        sync_q;
    logic [NCH-1:0]                         prev_q;
    logic [NCH-1:0]                         rise;
    logic [GW-1:0]                          gate_cnt_q, gate_cnt_d;
    logic [GW-1:0]                          gate_len_q, gate_len_d;
    logic [GW-1:0]                          sel_len;
    logic [NCH-1:0][CNT_W-1:0]              cnt_q, cnt_d;
    logic [NCH-1:0]                         ovf_run_q, ovf_run_d;
    logic [NCH-1:0][CNT_W-1:0]              freq_q;
    logic [NCH-1:0]                         ovf_q;
    logic                                   valid_q;

    // Input synchroniser chain followed by a rising-edge detector per channel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], mtr.sig_in};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

    always_comb begin
        sel_len = GL0;
        case (mtr.gate_sel)
            2'd0:    sel_len = GL0;
            2'd1:    sel_len = GL1;
            2'd2:    sel_len = GL2;
            default: sel_len = GL3;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        gate_cnt_d = gate_cnt_q;
        gate_len_d = gate_len_q;
        cnt_d      = cnt_q;
        ovf_run_d  = ovf_run_q;
        case (state_q)
            IDLE: begin
                gate_cnt_d = '0;
                cnt_d      = '0;
                ovf_run_d  = '0;
                if (mtr.en) begin
                    state_d    = GATE;
                    gate_len_d = sel_len;
                end
            end
            GATE: begin
                gate_cnt_d = gate_cnt_q + G_ONE;
                for (int k = 0; k < NCH; k++) begin
                    if (rise[k]) begin
                        // A saturated counter holds and marks the window as overflowed.
                        if (cnt_q[k] == C_MAX) ovf_run_d[k] = 1'b1;
                        else                   cnt_d[k]     = cnt_q[k] + C_ONE;
                    end
                end
                if (gate_cnt_q == gate_len_q - G_ONE) state_d = LATCH;
            end
            LATCH: begin
                // Edges seen in this cycle are intentionally dropped.
                gate_cnt_d = '0;
                cnt_d      = '0;
                ovf_run_d  = '0;
                if (mtr.en) begin
                    state_d    = GATE;
                    gate_len_d = sel_len;
                end else begin
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            gate_cnt_q <= '0;
            gate_len_q <= '0;
            cnt_q      <= '0;
            ovf_run_q  <= '0;
            freq_q     <= '0;
            ovf_q      <= '0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            gate_cnt_q <= gate_cnt_d;
            gate_len_q <= gate_len_d;
            cnt_q      <= cnt_d;
            ovf_run_q  <= ovf_run_d;
            valid_q    <= (state_q == LATCH);
            if (state_q == LATCH) begin
                freq_q <= cnt_q;
                ovf_q  <= ovf_run_q;
            end
        end
    end

    assign mtr.freq  = freq_q;
    assign mtr.ovf   = ovf_q;
    assign mtr.valid = valid_q;
    assign mtr.busy  = (state_q == GATE);
endmodule
